// File: rtl/tl_timer_if.sv
// Phase-timer bus: period load, slow enable tick, restart strobe and expiry flag.
interface tl_timer_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] tp_val;
    logic             enable;
    logic             start_t;
    logic             expired;

    modport master (
        output tp_val,
        output enable,
        output start_t,
        input  expired
    );

    modport slave (
        input  tp_val,
        input  enable,
        input  start_t,
        output expired
    );
endinterface

// File: rtl/tl_timer.sv
// Phase-duration timer: counts rising edges of a slow enable after start_t
// and raises expired once the loaded period (min 1 tick) has elapsed.
//
// state | meaning
// IDLE  | out of reset, no period loaded; ticks ignored, expired=0
// RUN   | counting ticks down from the loaded period
// DONE  | period elapsed; expired held high until start_t or reset
module tl_timer #(
    parameter int WIDTH = 4
) (
    input  logic        clk,
    input  logic        reset_sync,
    tl_timer_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] count_nxt;
    logic             en_d;
    logic             tick;

    assign tick = bus.enable & ~en_d;

    always_ff @(posedge clk) begin
        if (reset_sync) begin
            state <= IDLE;
            count <= '0;
            en_d  <= 1'b0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            en_d  <= bus.enable;
        end
    end

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        // start_t wins over a coincident tick, which is simply dropped
        if (bus.start_t) begin
            count_nxt = bus.tp_val;
            state_nxt = RUN;
        end else begin
            case (state)
                RUN: begin
                    if (tick) begin
                        if (count > WIDTH'(1)) begin
                            count_nxt = count - WIDTH'(1);
                        end else begin
                            // a period of 0 lands here on the first tick too
                            count_nxt = '0;
                            state_nxt = DONE;
                        end
                    end
                end
                default: begin
                    state_nxt = state;
                end
            endcase
        end
    end

    assign bus.expired = (state == DONE);
endmodule

// File: tb/tb_tl_timer.sv
// Bench for tl_timer: directed phase sequences from a vector table, then
// random stimulus against a tick-counting reference model.
module tb_tl_timer;
    localparam int WIDTH = 4;

    logic clk = 1'b0;
    logic reset_sync;
    always #5 clk = ~clk;

    tl_timer_if #(.WIDTH(WIDTH)) bus();
    tl_timer #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .reset_sync (reset_sync),
        .bus        (bus)
    );

    typedef struct {
        logic             rst;
        logic [WIDTH-1:0] tp;
        logic             en;
        logic             st;
        logic             exp;
    } vec_t;

    vec_t vecs[$];
    int   checks   = 0;
    int   failures = 0;

    // reference model: ticks seen since the last start versus ticks needed
    logic m_active;
    logic m_prev;
    int   m_seen;
    int   m_needed;

    task automatic add(input logic rst, input logic [WIDTH-1:0] tp,
                       input logic en, input logic st, input logic exp);
        vec_t v;
        v.rst = rst; v.tp = tp; v.en = en; v.st = st; v.exp = exp;
        vecs.push_back(v);
    endtask

    // 3 cycles enable low then 3 high; optional start on the rising cycle
    task automatic add_pulse(input logic st, input logic [WIDTH-1:0] tp,
                             input logic exp_low, input logic exp_high);
        for (int i = 0; i < 3; i++) add(1'b0, 4'hF, 1'b0, 1'b0, exp_low);
        add(1'b0, tp, 1'b1, st, exp_high);
        for (int i = 0; i < 2; i++) add(1'b0, 4'hF, 1'b1, 1'b0, exp_high);
    endtask

    task automatic apply(input logic rst, input logic [WIDTH-1:0] tp,
                         input logic en, input logic st);
        reset_sync  = rst;
        bus.tp_val  = tp;
        bus.enable  = en;
        bus.start_t = st;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic rst, input logic [WIDTH-1:0] tp,
                              input logic en, input logic st);
        logic rise;
        if (rst) begin
            m_active = 1'b0;
            m_prev   = 1'b0;
            m_seen   = 0;
            m_needed = 1;
        end else begin
            rise   = en & ~m_prev;
            m_prev = en;
            if (st) begin
                m_active = 1'b1;
                m_needed = (tp == 0) ? 1 : int'(tp);
                m_seen   = 0;
            end else if (m_active && rise && m_seen < m_needed) begin
                m_seen++;
            end
        end
    endtask

    function automatic logic model_expired();
        return m_active && (m_seen >= m_needed);
    endfunction

    initial begin
        logic             r_rst, r_en, r_st;
        logic [WIDTH-1:0] r_tp;

        reset_sync  = 1'b1;
        bus.tp_val  = '0;
        bus.enable  = 1'b0;
        bus.start_t = 1'b0;

        // 1 reset with enable high, then a tick out of reset in IDLE
        add(1'b1, 4'h0, 1'b1, 1'b0, 1'b0);
        add(1'b1, 4'h0, 1'b0, 1'b0, 1'b0);
        add(1'b1, 4'h0, 1'b1, 1'b0, 1'b0);
        add(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
        // 2 idle pulses
        for (int p = 0; p < 4; p++) add_pulse(1'b0, 4'hF, 1'b0, 1'b0);
        // 3 nominal period 3, start on an enable rise
        add_pulse(1'b1, 4'd3, 1'b0, 1'b0);
        add_pulse(1'b0, 4'hF, 1'b0, 1'b0);
        add_pulse(1'b0, 4'hF, 1'b0, 1'b0);
        add_pulse(1'b0, 4'hF, 1'b0, 1'b1);
        add_pulse(1'b0, 4'hF, 1'b1, 1'b1);
        add_pulse(1'b0, 4'hF, 1'b1, 1'b1);
        // 4 restart: period 5, two ticks, restart with period 2
        add_pulse(1'b1, 4'd5, 1'b1, 1'b0);
        add_pulse(1'b0, 4'hF, 1'b0, 1'b0);
        add_pulse(1'b0, 4'hF, 1'b0, 1'b0);
        add_pulse(1'b1, 4'd2, 1'b0, 1'b0);
        add_pulse(1'b0, 4'hF, 1'b0, 1'b0);
        add_pulse(1'b0, 4'hF, 1'b0, 1'b1);
        add_pulse(1'b0, 4'hF, 1'b1, 1'b1);
        // 5 zero period expires on first tick
        add_pulse(1'b1, 4'd0, 1'b1, 1'b0);
        add_pulse(1'b0, 4'hF, 1'b0, 1'b1);
        // 6 reset mid-count, later ticks ignored
        add_pulse(1'b1, 4'd4, 1'b1, 1'b0);
        add_pulse(1'b0, 4'hF, 1'b0, 1'b0);
        add_pulse(1'b0, 4'hF, 1'b0, 1'b0);
        add(1'b1, 4'hF, 1'b0, 1'b0, 1'b0);
        for (int p = 0; p < 4; p++) add_pulse(1'b0, 4'hF, 1'b0, 1'b0);
        // held start_t keeps reloading; counting begins after release
        add(1'b0, 4'd1, 1'b1, 1'b1, 1'b0);
        add(1'b0, 4'd1, 1'b0, 1'b1, 1'b0);
        add(1'b0, 4'd1, 1'b1, 1'b1, 1'b0);
        add(1'b0, 4'hF, 1'b1, 1'b0, 1'b0);
        add_pulse(1'b0, 4'hF, 1'b0, 1'b1);

        foreach (vecs[i]) begin
            apply(vecs[i].rst, vecs[i].tp, vecs[i].en, vecs[i].st);
            check($sformatf("vec%0d_expired", i), int'(bus.expired), int'(vecs[i].exp));
            if (vecs[i].rst) check($sformatf("vec%0d_count", i), int'(dut.count), 0);
        end

        // random phase, synchronised with the model by an initial reset
        model_step(1'b1, 4'h0, 1'b0, 1'b0);
        apply(1'b1, 4'h0, 1'b0, 1'b0);
        check("rand_reset_expired", int'(bus.expired), int'(model_expired()));
        r_en = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            r_rst = ($urandom_range(0, 99) == 0);
            r_st  = ($urandom_range(0, 24) == 0);
            r_tp  = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
            if ($urandom_range(0, 2) == 0) r_en = ~r_en;
            model_step(r_rst, r_tp, r_en, r_st);
            apply(r_rst, r_tp, r_en, r_st);
            check("rand_expired", int'(bus.expired), int'(model_expired()));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
